uart_rx: RTL

- Serial receiver for the 8N1 frames produced by the team's TX block: start bit 0, 8 data bits **MSB first**, stop bit 1, line idle high.
- Sits on the far end of the serial line and recovers each character using 16x oversampling derived from CLOCK_50.
- Presents each character on a parallel bus with a valid/acknowledge handshake.
- Flags framing and overrun errors.

---
 rtl/uart_rx.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver, MSB first, 16x oversampled from CLOCK_50.
// Optional even parity (8E1) when UART_RX_PARITY_EN is defined.
//
// Ports:
//   CLOCK_50     system clock, all state on rising edge
//   reset        synchronous active-high reset
//   RxIn         asynchronous serial line, idle high
//   DataOut      last correctly received character
//   dataValid    DataOut holds an unread character
//   charRead     consumer acknowledge (pulse or level)
//   framingError sticky, last frame had stop bit 0
//   overrun      sticky, good frame dropped while dataValid was high
//   parityError  sticky, parity check failed (UART_RX_PARITY_EN only)
//   busy         receiver is inside a frame
module uart_rx #(
    parameter int CLK_DIV    = 301,
    parameter int OVERSAMPLE = 16
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       RxIn,
    output logic [7:0] DataOut,
    output logic       dataValid,
    input  logic       charRead,
    output logic       framingError,
    output logic       overrun,
`ifdef UART_RX_PARITY_EN
    output logic       parityError,
`endif
    output logic       busy
);

    localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] TLAST = CW'(CLK_DIV - 1);
    localparam logic [3:0] SMID = 4'(OVERSAMPLE - 1);
    localparam logic [3:0] SHALF = 4'(OVERSAMPLE / 2 - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    logic          sync1;
    logic          rx_s;
    logic [CW-1:0] tcnt;
    logic          tick;

    state_t     state, state_n;
    logic [3:0] scnt, scnt_n;
    logic [2:0] bcnt, bcnt_n;
    logic [7:0] shreg, shreg_n;
    logic [7:0] data_n;
    logic       dv_n, fe_n, ov_n;
    logic       done;
    logic       good;
`ifdef UART_RX_PARITY_EN
    logic       par_err, par_err_n;
    logic       pe_n;
`endif

    // Two-flop synchronizer; flops reset to the idle level.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            sync1 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            sync1 <= RxIn;
            rx_s  <= sync1;
        end
    end

    assign tick = (tcnt == TLAST);

    always_ff @(posedge CLOCK_50) begin
        if (reset)
            tcnt <= '0;
        else if (tick)
            tcnt <= '0;
        else
            tcnt <= tcnt + 1'b1;
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state        <= IDLE;
            scnt         <= '0;
            bcnt         <= '0;
            shreg        <= '0;
            DataOut      <= '0;
            dataValid    <= 1'b0;
            framingError <= 1'b0;
            overrun      <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_err      <= 1'b0;
            parityError  <= 1'b0;
`endif
        end else begin
            state        <= state_n;
            scnt         <= scnt_n;
            bcnt         <= bcnt_n;
            shreg        <= shreg_n;
            DataOut      <= data_n;
            dataValid    <= dv_n;
            framingError <= fe_n;
            overrun      <= ov_n;
`ifdef UART_RX_PARITY_EN
            par_err      <= par_err_n;
            parityError  <= pe_n;
`endif
        end
    end

    always_comb begin
        state_n = state;
        scnt_n  = scnt;
        bcnt_n  = bcnt;
        shreg_n = shreg;
        done    = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_err_n = par_err;
`endif
        if (tick) begin
            unique case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state_n = START;
                        scnt_n  = 4'd1;
                    end
                end
                START: begin
                    scnt_n = scnt + 4'd1;
                    if (scnt == SHALF) begin
                        // A line that is high again mid start bit was a glitch.
                        if (!rx_s) begin
                            scnt_n  = '0;
                            bcnt_n  = '0;
                            state_n = DATA;
                        end else begin
                            state_n = IDLE;
                        end
                    end
                end
                DATA: begin
                    scnt_n = scnt + 4'd1;
                    if (scnt == SMID) begin
                        shreg_n = {shreg[6:0], rx_s};
                        if (bcnt == 3'd7) begin
                            scnt_n = '0;
`ifdef UART_RX_PARITY_EN
                            state_n = PARITY;
`else
                            state_n = STOP;
`endif
                        end else begin
                            bcnt_n = bcnt + 3'd1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    scnt_n = scnt + 4'd1;
                    if (scnt == SMID) begin
                        // Even parity: data plus parity bit must XOR to 0.
                        par_err_n = ^{shreg, rx_s};
                        scnt_n    = '0;
                        state_n   = STOP;
                    end
                end
`endif
                STOP: begin
                    scnt_n = scnt + 4'd1;
                    if (scnt == SMID) begin
                        done    = 1'b1;
                        state_n = IDLE;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

`ifdef UART_RX_PARITY_EN
    assign good = rx_s && !par_err;
`else
    assign good = rx_s;
`endif

    // Acknowledge clears first; a flag raised by the frame finishing in
    // the same cycle then wins over the clear.
    always_comb begin
        data_n = DataOut;
        dv_n   = dataValid;
        fe_n   = framingError;
        ov_n   = overrun;
`ifdef UART_RX_PARITY_EN
        pe_n   = parityError;
`endif
        if (charRead) begin
            dv_n = 1'b0;
            fe_n = 1'b0;
            ov_n = 1'b0;
`ifdef UART_RX_PARITY_EN
            pe_n = 1'b0;
`endif
        end
        if (done) begin
            if (!rx_s)
                fe_n = 1'b1;
`ifdef UART_RX_PARITY_EN
            if (par_err)
                pe_n = 1'b1;
`endif
            if (good) begin
                if (!dataValid || charRead) begin
                    data_n = shreg;
                    dv_n   = 1'b1;
                end else begin
                    ov_n = 1'b1;
                end
            end
        end
    end

    assign busy = (state != IDLE);

endmodule
